key_onehot_capture: RTL and testbench

KEY_ONEHOT_CAPTURE -- requirements
Module: key_onehot_capture

---
 rtl/key_onehot_capture_pkg.sv | 25 ++
 rtl/key_debounce.sv | 54 +++++
 rtl/key_onehot_capture.sv | 113 +++++++++++
 tb/tb_key_onehot_capture.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_onehot_capture_pkg.sv
// Shared constants, FSM encodings and helpers for key_onehot_capture.
// Holds KEY_W, the default debounce window and the one-hot bit helpers.
package key_onehot_capture_pkg;

    localparam int KEY_W          = 8;
    localparam int DEB_CYCLES_DEF = 4;
    localparam int CNT_W          = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Two or more bits set: clearing the lowest set bit leaves something.
    function automatic logic is_multi(input logic [KEY_W-1:0] v);
        return (v & (v - KEY_W'(1))) != '0;
    endfunction

    // Isolate the lowest-index set bit (two's complement trick).
    function automatic logic [KEY_W-1:0] lowest_bit(input logic [KEY_W-1:0] v);
        return v & (~v + KEY_W'(1));
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer followed by a consecutive-mismatch debouncer.
// Ports: clk, rst_n, key_i (async level), deb_o (debounced level).
module key_debounce
    import key_onehot_capture_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic deb_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             deb_q;
    logic             deb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter tracks how many consecutive cycles the synchronized
    // level has disagreed with the debounced level; any agreement resets it.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == LAST) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_o = deb_q;

endmodule

// File: rtl/key_onehot_capture.sv
// Debounces KEY_W keys and captures a single pressed key as a one-hot word
// for a downstream 8-to-3 encoder, with a valid/ready handshake.
// Ports: clk, rst_n (async, active-low), key_raw, data_ready -> data,
// data_valid, multi_err (one-cycle pulse on an illegal multi-key press).
// Build option: define KEY_PRIORITY_EN to capture the lowest-index key of a
// multi-key press instead of flagging multi_err.
module key_onehot_capture
    import key_onehot_capture_pkg::*;
#(
    parameter int DEB_CYCLES = key_onehot_capture_pkg::DEB_CYCLES_DEF,
    parameter int KEY_W      = key_onehot_capture_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_raw,
    input  logic             data_ready,
    output logic [KEY_W-1:0] data,
    output logic             data_valid,
    output logic             multi_err
);

    logic [KEY_W-1:0] deb_vec;

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .key_i(key_raw[i]),
            .deb_o(deb_vec[i])
        );
    end

    state_e           state_q;
    state_e           state_d;
    logic [KEY_W-1:0] data_q;
    logic [KEY_W-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    logic             err_q;
    logic             err_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                data_d  = '0;
                valid_d = 1'b0;
                if (deb_vec != '0) begin
                    if (!is_multi(deb_vec)) begin
                        state_d = ST_HOLD;
                        data_d  = deb_vec;
                        valid_d = 1'b1;
                    end else begin
`ifdef KEY_PRIORITY_EN
                        state_d = ST_HOLD;
                        data_d  = lowest_bit(deb_vec);
                        valid_d = 1'b1;
`else
                        state_d = ST_RELEASE;
                        err_d   = 1'b1;
`endif
                    end
                end
            end
            // Word is held regardless of key release until accepted.
            ST_HOLD: begin
                if (valid_q && data_ready) begin
                    state_d = ST_RELEASE;
                    data_d  = '0;
                    valid_d = 1'b0;
                end
            end
            // Ignore everything until all keys are up.
            ST_RELEASE: begin
                data_d  = '0;
                valid_d = 1'b0;
                if (deb_vec == '0) begin
                    state_d = ST_IDLE;
                end
            end
            // Unused encoding recovers to IDLE.
            default: begin
                state_d = ST_IDLE;
                data_d  = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;
    assign multi_err  = err_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// Self-checking bench for key_onehot_capture: vector table plus
// hand-written multi-cycle sequences, with an event scoreboard.
module tb_key_onehot_capture;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_raw;
    logic       data_ready;
    logic [7:0] data;
    logic       data_valid;
    logic       multi_err;

    key_onehot_capture #(
        .DEB_CYCLES(4),
        .KEY_W     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw   (key_raw),
        .data_ready(data_ready),
        .data      (data),
        .data_valid(data_valid),
        .multi_err (multi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } evt_t;

    typedef struct {
        logic [7:0] key;
        bit         is_err;
        logic [7:0] data;
    } vec_t;

    evt_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    int   t0     = 0;

    task automatic chk(input bit ok, input string nm,
                       input int act, input int exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                      nm, act, exp, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: invariants every cycle, scoreboard on each output event.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            bit         got;
            bit         got_err;
            logic [7:0] got_data;
            evt_t       e;
            chk(data_valid || data == 8'h00, "zero_when_invalid",
                int'(data), 0);
            chk(data == 8'h00 || (data & (data - 8'h01)) == 8'h00,
                "onehot", int'(data), 0);
            got = 1'b0;
            got_err = 1'b0;
            got_data = 8'h00;
            if (data_valid && data_ready) begin
                got = 1'b1;
                got_data = data;
            end
            if (multi_err) begin
                got = 1'b1;
                got_err = 1'b1;
            end
            if (got) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_evt", {got_err, got_data}, 0);
                end else begin
                    e = sb.pop_front();
                    chk(e.is_err == got_err && e.data == got_data, "sb_evt",
                        {got_err, got_data}, {e.is_err, e.data});
                end
            end
        end
    end

    // Wait for data_valid or multi_err, bounded; latency measured from t0.
    task automatic wait_evt(output int lat, output bit ok);
        ok = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (data_valid || multi_err) begin
                ok = 1'b1;
                lat = cyc - t0;
                break;
            end
        end
    endtask

    vec_t vecs[7];

    initial begin
        int lat;
        bit ok;
        bit seen;
        bit stable;

        vecs[0] = '{8'h04, 1'b0, 8'h04};
        vecs[1] = '{8'h01, 1'b0, 8'h01};
        vecs[2] = '{8'h80, 1'b0, 8'h80};
`ifdef KEY_PRIORITY_EN
        vecs[3] = '{8'h81, 1'b0, 8'h01};
        vecs[4] = '{8'h18, 1'b0, 8'h08};
        vecs[5] = '{8'hFF, 1'b0, 8'h01};
`else
        vecs[3] = '{8'h81, 1'b1, 8'h00};
        vecs[4] = '{8'h18, 1'b1, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 8'h00};
`endif
        vecs[6] = '{8'h40, 1'b0, 8'h40};

        rst_n = 1'b0;
        key_raw = 8'h00;
        data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(data == 8'h00, "reset_data", int'(data), 0);
        chk(!data_valid, "reset_valid", int'(data_valid), 0);
        chk(!multi_err, "reset_err", int'(multi_err), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Table: single and multi-key presses with ready held high.
        data_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            key_raw = vecs[i].key;
            t0 = cyc;
            sb.push_back('{vecs[i].is_err, vecs[i].data});
            wait_evt(lat, ok);
            chk(ok, "evt_timeout", int'(ok), 1);
            chk(lat == 7, "evt_latency", lat, 7);
            @(negedge clk);
            #1;
            chk(!data_valid && !multi_err && data == 8'h00, "one_cycle",
                {data_valid, multi_err, data}, 0);
            key_raw = 8'h00;
            repeat (12) @(posedge clk);
            #1;
        end

        // Glitching key: 3 on / 3 off never outlasts the window.
        seen = 1'b0;
        for (int c = 0; c < 36; c++) begin
            key_raw = (((c / 3) % 2) == 0) ? 8'h10 : 8'h00;
            @(negedge clk);
            if (data_valid || multi_err) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        chk(!seen, "glitch_no_capture", int'(seen), 0);
        key_raw = 8'h00;
        repeat (12) @(posedge clk);
        #1;

        // Back-pressure: word held while ready low, key released meanwhile.
        data_ready = 1'b0;
        key_raw = 8'h20;
        t0 = cyc;
        sb.push_back('{1'b0, 8'h20});
        wait_evt(lat, ok);
        chk(ok && lat == 7, "bp_latency", lat, 7);
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) key_raw = 8'h00;
            @(negedge clk);
            #1;
            if (!(data_valid && data == 8'h20)) stable = 1'b0;
        end
        chk(stable, "bp_hold_stable", int'(stable), 1);
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        chk(!data_valid && data == 8'h00, "bp_cleared",
            {data_valid, data}, 0);
        repeat (12) @(posedge clk);
        #1;

        // Extra press while in RELEASE is ignored; fresh press captured.
        key_raw = 8'h01;
        t0 = cyc;
        sb.push_back('{1'b0, 8'h01});
        wait_evt(lat, ok);
        chk(ok && data == 8'h01, "rel_first", int'(data), 1);
        @(posedge clk);
        #1;
        key_raw = 8'h03;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            #1;
            if (data_valid || multi_err) seen = 1'b1;
        end
        chk(!seen, "rel_ignored", int'(seen), 0);
        key_raw = 8'h00;
        repeat (12) @(posedge clk);
        #1;
        key_raw = 8'h02;
        t0 = cyc;
        sb.push_back('{1'b0, 8'h02});
        wait_evt(lat, ok);
        chk(ok && lat == 7, "rel_second_lat", lat, 7);
        chk(data == 8'h02, "rel_second_data", int'(data), 2);
        key_raw = 8'h00;
        repeat (12) @(posedge clk);
        #1;

        // Reset mid-HOLD with key held: discard, then recapture.
        data_ready = 1'b0;
        key_raw = 8'h08;
        wait_evt(lat, ok);
        chk(ok && data == 8'h08, "rst_pre_hold", int'(data), 8);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk(data == 8'h00 && !data_valid && !multi_err, "rst_immediate",
            {data_valid, multi_err, data}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = cyc;
        sb.push_back('{1'b0, 8'h08});
        wait_evt(lat, ok);
        chk(ok && lat == 7, "rst_recap_lat", lat, 7);
        chk(data == 8'h08, "rst_recap_data", int'(data), 8);
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        chk(!data_valid && data == 8'h00, "rst_drain",
            {data_valid, data}, 0);
        key_raw = 8'h00;
        repeat (12) @(posedge clk);
        #1;

        chk(sb.size() == 0, "sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
